pixel_color_gen: RTL and testbench

- Per-pixel colour source sitting directly upstream of color_mapper.
- Takes DrawX/DrawY from the VGA controller and composites one 32x32 palette-indexed sprite over a background.
- The sprite is read from an external synchronous ROM; background is palette entry 0.
- Emits a 24-bit {R,G,B} colour plus delayed DrawX/DrawY, aligned for color_mapper, at a fixed 2-cycle latency.

---
 rtl/pixel_color_gen_pkg.sv | 12 +
 rtl/pixel_color_gen_palette.sv | 32 +++
 rtl/pixel_color_gen.sv | 171 +++++++++++++++++
 tb/tb_pixel_color_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_color_gen_pkg.sv
// Shared types and constants for the sprite/background pixel colour source.
// Holds the colour and palette-index types plus frame/pipeline constants.
package pixel_pkg;

  typedef logic [23:0] color_t;
  typedef logic [3:0]  pal_idx_t;

  localparam int       V_ACTIVE        = 480;
  localparam pal_idx_t TRANSPARENT_IDX = 4'd0;
  localparam int       PIPE_LAT        = 2;

endpackage

// File: rtl/pixel_color_gen_palette.sv
// Palette register file: DEPTH x 24-bit entries, one write port, one
// combinational read port; a same-cycle read of the written entry sees the old value.
module palette_regfile
  import pixel_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  color_t                   wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output color_t                   rdata_o
);

  color_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read comes from the registered array, so a write only shows up after its edge.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pixel_color_gen.sv
// Composites one palette-indexed sprite over palette entry 0 with a fixed 2-cycle
// latency. Optional horizontal mirroring is enabled by defining SPRITE_MIRROR_EN.
module pixel_color_gen
  import pixel_pkg::*;
#(
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 32,
  parameter int PAL_DEPTH = 16,
  parameter int V_ACTIVE  = 480
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  input  logic                         blank_n,
  input  logic [9:0]                   sprite_x,
  input  logic [9:0]                   sprite_y,
  input  logic                         sprite_update,
`ifdef SPRITE_MIRROR_EN
  input  logic                         sprite_mirror,
`endif
  input  logic                         pal_we,
  input  logic [$clog2(PAL_DEPTH)-1:0] pal_waddr,
  input  logic [23:0]                  pal_wdata,
  output logic [9:0]                   sprite_rom_addr,
  input  logic [$clog2(PAL_DEPTH)-1:0] sprite_rom_data,
  output logic [23:0]                  color,
  output logic [9:0]                   DrawX_out,
  output logic [9:0]                   DrawY_out
);

  localparam int XW    = $clog2(SPRITE_W);
  localparam int YW    = $clog2(SPRITE_H);
  localparam int IDX_W = $clog2(PAL_DEPTH);

  logic mirror_in;
`ifdef SPRITE_MIRROR_EN
  assign mirror_in = sprite_mirror;
`else
  assign mirror_in = 1'b0;
`endif

  // Double-buffered sprite position: pending captures updates, active is used for rendering
  logic [9:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [9:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic       pend_m_q, pend_m_d, act_m_q, act_m_d;
  logic       pend_vld_q, pend_vld_d;
  logic       vblank_start;

  assign vblank_start = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));

  always_comb begin
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pend_m_d   = pend_m_q;
    pend_vld_d = pend_vld_q;
    act_x_d    = act_x_q;
    act_y_d    = act_y_q;
    act_m_d    = act_m_q;
    if (vblank_start) begin
      pend_vld_d = 1'b0;
      if (sprite_update) begin
        act_x_d = sprite_x;
        act_y_d = sprite_y;
        act_m_d = mirror_in;
      end else if (pend_vld_q) begin
        act_x_d = pend_x_q;
        act_y_d = pend_y_q;
        act_m_d = pend_m_q;
      end
    end else if (sprite_update) begin
      pend_x_d   = sprite_x;
      pend_y_d   = sprite_y;
      pend_m_d   = mirror_in;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend_x_q   <= 10'h3FF;
      pend_y_q   <= 10'h3FF;
      pend_m_q   <= 1'b0;
      pend_vld_q <= 1'b0;
      act_x_q    <= 10'h3FF;
      act_y_q    <= 10'h3FF;
      act_m_q    <= 1'b0;
    end else begin
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_m_q   <= pend_m_d;
      pend_vld_q <= pend_vld_d;
      act_x_q    <= act_x_d;
      act_y_q    <= act_y_d;
      act_m_q    <= act_m_d;
    end
  end

  // Stage 0: signed offsets into the sprite, hit test and ROM address
  logic signed [10:0] dx_p0, dy_p0;
  logic               hit_p0;
  logic [XW-1:0]      col_p0;

  assign dx_p0  = $signed({1'b0, DrawX}) - $signed({1'b0, act_x_q});
  assign dy_p0  = $signed({1'b0, DrawY}) - $signed({1'b0, act_y_q});
  assign hit_p0 = !dx_p0[10] && (dx_p0[9:0] < 10'(SPRITE_W)) &&
                  !dy_p0[10] && (dy_p0[9:0] < 10'(SPRITE_H));
  // Power-of-two width makes SPRITE_W-1-dx a plain bit inversion.
  assign col_p0 = act_m_q ? ~dx_p0[XW-1:0] : dx_p0[XW-1:0];

  assign sprite_rom_addr = hit_p0 ? 10'({dy_p0[YW-1:0], col_p0}) : 10'd0;

  logic       vld_p1_q, hit_p1_q, blank_p1_q;
  logic [9:0] x_p1_q, y_p1_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p1_q   <= 1'b0;
      hit_p1_q   <= 1'b0;
      blank_p1_q <= 1'b0;
      x_p1_q     <= '0;
      y_p1_q     <= '0;
    end else begin
      vld_p1_q   <= 1'b1;
      hit_p1_q   <= hit_p0;
      blank_p1_q <= blank_n;
      x_p1_q     <= DrawX;
      y_p1_q     <= DrawY;
    end
  end

  // Stage 1: ROM index arrives, palette lookup, blanking
  logic [IDX_W-1:0] idx_p1;
  color_t           pal_rdata_p1;
  color_t           color_d;

  assign idx_p1  = hit_p1_q ? sprite_rom_data : IDX_W'(TRANSPARENT_IDX);
  assign color_d = (vld_p1_q && blank_p1_q) ? pal_rdata_p1 : '0;

  palette_regfile #(
    .DEPTH (PAL_DEPTH)
  ) u_palette (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (pal_we),
    .waddr_i (pal_waddr),
    .wdata_i (pal_wdata),
    .raddr_i (idx_p1),
    .rdata_o (pal_rdata_p1)
  );

  color_t     color_p2_q;
  logic [9:0] x_p2_q, y_p2_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      color_p2_q <= '0;
      x_p2_q     <= '0;
      y_p2_q     <= '0;
    end else begin
      color_p2_q <= color_d;
      x_p2_q     <= x_p1_q;
      y_p2_q     <= y_p1_q;
    end
  end

  assign color     = color_p2_q;
  assign DrawX_out = x_p2_q;
  assign DrawY_out = y_p2_q;

endmodule

// File: tb/tb_pixel_color_gen.sv
// Directed bench for pixel_color_gen: table of single-pixel vectors plus
// hand-written sequences for latency, palette hazards, buffering and reset.
module tb_pixel_color_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  draw_x, draw_y;
  logic        blank_n;
  logic [9:0]  spr_x, spr_y;
  logic        spr_upd;
  logic        spr_mir;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [23:0] pal_wdata;
  logic [9:0]  rom_addr;
  logic [3:0]  rom_data;
  logic [23:0] color;
  logic [9:0]  x_out, y_out;

  logic [3:0]  rom_mem [1024];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pixel_color_gen dut (
    .Clk             (clk),
    .Reset           (rst),
    .DrawX           (draw_x),
    .DrawY           (draw_y),
    .blank_n         (blank_n),
    .sprite_x        (spr_x),
    .sprite_y        (spr_y),
    .sprite_update   (spr_upd),
`ifdef SPRITE_MIRROR_EN
    .sprite_mirror   (spr_mir),
`endif
    .pal_we          (pal_we),
    .pal_waddr       (pal_waddr),
    .pal_wdata       (pal_wdata),
    .sprite_rom_addr (rom_addr),
    .sprite_rom_data (rom_data),
    .color           (color),
    .DrawX_out       (x_out),
    .DrawY_out       (y_out)
  );

  // Synchronous sprite ROM model: data one cycle after address
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic [9:0]  addr;
    logic [23:0] col;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [9:0] x, input logic [9:0] y);
    draw_x = x;
    draw_y = y;
  endtask

  task automatic write_pal(input logic [3:0] a, input logic [23:0] d);
    pal_we    = 1'b1;
    pal_waddr = a;
    pal_wdata = d;
    step();
    pal_we    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'd0;
    rom_mem[10'd98]   = 4'd5;  // {dy=3, dx=2}
    rom_mem[10'd0]    = 4'd7;  // {dy=0, dx=0}
    rom_mem[10'd1023] = 4'd3;  // {dy=31, dx=31}

    // sprite at (100,50) after commit; palette: 0=3F007F 3=00FF00 5=FF0000 7=0000FF
    vecs[0] = '{10'd102, 10'd53, 1'b1, 10'd98,   24'hFF0000};
    vecs[1] = '{10'd103, 10'd53, 1'b1, 10'd99,   24'h3F007F};
    vecs[2] = '{10'd100, 10'd50, 1'b1, 10'd0,    24'h0000FF};
    vecs[3] = '{10'd131, 10'd81, 1'b1, 10'd1023, 24'h00FF00};
    vecs[4] = '{10'd132, 10'd53, 1'b1, 10'd0,    24'h3F007F};
    vecs[5] = '{10'd99,  10'd53, 1'b1, 10'd0,    24'h3F007F};
    vecs[6] = '{10'd102, 10'd82, 1'b1, 10'd0,    24'h3F007F};
    vecs[7] = '{10'd102, 10'd53, 1'b0, 10'd98,   24'h000000};
    vecs[8] = '{10'd5,   10'd5,  1'b1, 10'd0,    24'h3F007F};

    rst = 1'b1; draw_x = '0; draw_y = '0; blank_n = 1'b1;
    spr_x = '0; spr_y = '0; spr_upd = 1'b0; spr_mir = 1'b0;
    pal_we = 1'b0; pal_waddr = '0; pal_wdata = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_color", 32'(color), 32'h0);
    check("reset_xout", 32'(x_out), 32'h0);
    check("reset_yout", 32'(y_out), 32'h0);

    // Off-screen sprite after reset: background (all-zero palette), no hit
    set_pix(10'd100, 10'd50);
    #1;
    check("post_reset_addr", 32'(rom_addr), 32'h0);
    step();
    check("post_reset_lat1_x", 32'(x_out), 32'h0);
    step();
    check("post_reset_color", 32'(color), 32'h0);
    check("post_reset_xout", 32'(x_out), 32'd100);
    check("post_reset_yout", 32'(y_out), 32'd50);

    write_pal(4'd0, 24'h3F007F);
    write_pal(4'd5, 24'hFF0000);
    write_pal(4'd3, 24'h00FF00);
    write_pal(4'd7, 24'h0000FF);

    // Pending update, then commit at vblank start
    set_pix(10'd10, 10'd10);
    spr_x = 10'd100; spr_y = 10'd50; spr_upd = 1'b1;
    step();
    spr_upd = 1'b0;
    set_pix(10'd102, 10'd53);
    #1;
    check("pending_not_active", 32'(rom_addr), 32'h0);
    set_pix(10'd0, 10'd480);
    step();

    for (int i = 0; i < 9; i++) begin
      set_pix(vecs[i].x, vecs[i].y);
      blank_n = vecs[i].blank;
      #1;
      check($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      step();
      step();
      check($sformatf("vec%0d_color", i), 32'(color), 32'(vecs[i].col));
      check($sformatf("vec%0d_xout", i), 32'(x_out), 32'(vecs[i].x));
      check($sformatf("vec%0d_yout", i), 32'(y_out), 32'(vecs[i].y));
    end
    blank_n = 1'b1;

    // Back-to-back pixels: one result per cycle, exactly two cycles behind
    set_pix(10'd102, 10'd53);
    step();
    set_pix(10'd103, 10'd53);
    step();
    check("stream0_color", 32'(color), 32'hFF0000);
    check("stream0_x", 32'(x_out), 32'd102);
    set_pix(10'd100, 10'd50);
    step();
    check("stream1_color", 32'(color), 32'h3F007F);
    check("stream1_x", 32'(x_out), 32'd103);
    step();
    check("stream2_color", 32'(color), 32'h0000FF);

    // Palette write to entry 5 while stage 1 reads entry 5
    set_pix(10'd102, 10'd53);
    step();
    pal_we = 1'b1; pal_waddr = 4'd5; pal_wdata = 24'h123456;
    step();
    pal_we = 1'b0;
    check("rbw_old_value", 32'(color), 32'hFF0000);
    step();
    check("rbw_new_value", 32'(color), 32'h123456);

    // Two mid-frame updates: last wins, applied only at vblank start
    set_pix(10'd5, 10'd10);
    spr_x = 10'd300; spr_y = 10'd300; spr_upd = 1'b1;
    step();
    spr_x = 10'd200; spr_y = 10'd200;
    step();
    spr_upd = 1'b0;
    set_pix(10'd102, 10'd53);
    #1;
    check("dbuf_old_hit", 32'(rom_addr), 32'd98);
    set_pix(10'd210, 10'd210);
    #1;
    check("dbuf_new_nohit", 32'(rom_addr), 32'h0);
    set_pix(10'd1, 10'd480);
    step();
    set_pix(10'd210, 10'd210);
    #1;
    check("dbuf_not_at_x1", 32'(rom_addr), 32'h0);
    set_pix(10'd0, 10'd480);
    step();
    set_pix(10'd210, 10'd210);
    #1;
    check("dbuf_new_hit", 32'(rom_addr), 32'd330);
    set_pix(10'd310, 10'd310);
    #1;
    check("dbuf_last_wins", 32'(rom_addr), 32'h0);
    set_pix(10'd102, 10'd53);
    #1;
    check("dbuf_old_gone", 32'(rom_addr), 32'h0);

    // Update coinciding with vblank start goes straight to active; clipping corner
    set_pix(10'd0, 10'd480);
    spr_x = 10'd630; spr_y = 10'd470; spr_upd = 1'b1; spr_mir = 1'b1;
    step();
    spr_upd = 1'b0; spr_mir = 1'b0;
    set_pix(10'd639, 10'd479);
    #1;
`ifdef SPRITE_MIRROR_EN
    check("corner_hit", 32'(rom_addr), 32'd310);
`else
    check("corner_hit", 32'(rom_addr), 32'd297);
`endif
    set_pix(10'd630, 10'd470);
    #1;
`ifdef SPRITE_MIRROR_EN
    check("corner_origin", 32'(rom_addr), 32'd31);
`else
    check("corner_origin", 32'(rom_addr), 32'd0);
`endif
    set_pix(10'd5, 10'd5);
    #1;
    check("corner_far_nohit", 32'(rom_addr), 32'h0);
    set_pix(10'd0, 10'd480);
    step();
    set_pix(10'd639, 10'd479);
    #1;
`ifdef SPRITE_MIRROR_EN
    check("corner_stays", 32'(rom_addr), 32'd310);
`else
    check("corner_stays", 32'(rom_addr), 32'd297);
`endif

    // Reset mid-frame: two zero cycles, then the pipeline refills
    set_pix(10'd102, 10'd53);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_color0", 32'(color), 32'h0);
    check("midrst_x0", 32'(x_out), 32'h0);
    step();
    check("midrst_color1", 32'(color), 32'h0);
    check("midrst_x1", 32'(x_out), 32'h0);
    step();
    check("midrst_x2", 32'(x_out), 32'd102);
    check("midrst_y2", 32'(y_out), 32'd53);
    check("midrst_color2", 32'(color), 32'h0);
    #1;
    check("midrst_addr", 32'(rom_addr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
